// File: rtl/btn_cond_pkg.sv
// Shared types and 50 MHz board defaults for the button/switch conditioner.
// Optional auto-repeat is enabled by defining BTN_COND_REPEAT_EN.
package btn_cond_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEF_CNT_W           = 16;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
  localparam int unsigned RPT_CNT_W           = 32;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } btn_state_e;

  // Per-channel conditioned outputs (rel = release, rpt = repeat).
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic rpt;
  } btn_evt_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One conditioned channel: 2-flop synchronizer, debounce FSM, event pulses.
// BTN_COND_REPEAT_EN adds a per-channel auto-repeat counter.
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
`ifdef BTN_COND_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     raw,
  output btn_evt_t evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1, sync2;
  btn_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_q, level_nxt;
  logic             press_q, press_nxt;
  logic             rel_q, rel_nxt;

  // Synchronizer; sync2 is the only raw-derived signal the FSM sees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_LOW;
      cnt     <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      level_q <= level_nxt;
      press_q <= press_nxt;
      rel_q   <= rel_nxt;
    end
  end

  // Wait states count consecutive agreeing samples; any disagreement is a glitch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level_q;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    case (state)
      ST_LOW: begin
        if (sync2) begin
          state_nxt = ST_RISE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_RISE_WAIT: begin
        if (!sync2) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sync2) begin
          state_nxt = ST_FALL_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_FALL_WAIT: begin
        if (sync2) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
          rel_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef BTN_COND_REPEAT_EN
  // After firing, reload so the next fire lands REPEAT_PERIOD cycles later.
  localparam logic [RPT_CNT_W-1:0] RPT_FIRE   = RPT_CNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [RPT_CNT_W-1:0] RPT_RELOAD = RPT_CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic                 rpt_q, rpt_nxt;
  logic                 held;

  assign held = (state == ST_HIGH) || (state == ST_FALL_WAIT);

  // FALL_WAIT keeps counting so a bounce during hold does not disturb cadence.
  always_comb begin
    rpt_cnt_nxt = rpt_cnt;
    rpt_nxt     = 1'b0;
    if (!held || (state_nxt == ST_LOW)) begin
      rpt_cnt_nxt = '0;
    end else if (rpt_cnt == RPT_FIRE) begin
      rpt_cnt_nxt = RPT_RELOAD;
      rpt_nxt     = 1'b1;
    end else begin
      rpt_cnt_nxt = rpt_cnt + RPT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt <= '0;
      rpt_q   <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt_nxt;
      rpt_q   <= rpt_nxt;
    end
  end

  assign evt = '{level: level_q, press: press_q, rel: rel_q, rpt: rpt_q};
`else
  assign evt = '{level: level_q, press: press_q, rel: rel_q, rpt: 1'b0};
`endif

endmodule

// File: rtl/btn_cond.sv
// Conditions btn[3:0] (bits 3:0) and sw[4:0] (bits 8:4) for the stopwatch.
// release/repeat are keywords, hence release_pulse/repeat_pulse; BTN_COND_REPEAT_EN enables repeat.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int unsigned N               = 9,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
`ifdef BTN_COND_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] repeat_pulse
);

  // Channels are fully independent.
  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_evt_t evt;

    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
`ifdef BTN_COND_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .raw (raw_in[i]),
      .evt (evt)
    );

    assign level[i]         = evt.level;
    assign press[i]         = evt.press;
    assign release_pulse[i] = evt.rel;
    assign repeat_pulse[i]  = evt.rpt;
  end

endmodule

// File: tb/tb_btn_cond.sv
// Self-checking bench for btn_cond with DEBOUNCE_CYCLES=4; repeat cadence
// is checked when BTN_COND_REPEAT_EN is defined.
`timescale 1ns/1ps
module tb_btn_cond;

  localparam int unsigned N   = 9;
  localparam int unsigned D   = 4;
  localparam int unsigned LAT = D + 1;
`ifdef BTN_COND_REPEAT_EN
  localparam int unsigned RD  = 10;
  localparam int unsigned RP  = 4;
`endif
  localparam logic [1:0] K_PRESS = 2'd0;
  localparam logic [1:0] K_REL   = 2'd1;
  localparam logic [1:0] K_RPT   = 2'd2;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  ch;
    logic [1:0]  kind;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] raw_in;
  logic [N-1:0] level, press, release_pulse, repeat_pulse;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];

  btn_cond #(
    .N               (N),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (16)
`ifdef BTN_COND_REPEAT_EN
    ,
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .raw_in        (raw_in),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; a pulse seen at a negedge came from edge cyc.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int unsigned c, input int ch, input logic [1:0] kd);
    ev_t r;
    r.cyc  = c;
    r.ch   = 8'(ch);
    r.kind = kd;
    return r;
  endfunction

  // Output monitor: every pulse the DUT produces, in time then channel order.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (press[i] !== 1'b0)         obs_q.push_back(mk_ev(cyc, i, K_PRESS));
      if (release_pulse[i] !== 1'b0) obs_q.push_back(mk_ev(cyc, i, K_REL));
      if (repeat_pulse[i] !== 1'b0)  obs_q.push_back(mk_ev(cyc, i, K_RPT));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    ev_t e, o;
    rst    = 1'b1;
    raw_in = '0;
    step(3);
    checks++;
    if ({level, press, release_pulse, repeat_pulse} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {level, press, release_pulse, repeat_pulse});
    end
    rst = 1'b0;
    step(2 * LAT);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL reset_events: missing event, required ch%0d kind%0d edge %0d", e.ch, e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL reset_events: got ch%0d kind%0d edge %0d required ch%0d kind%0d edge %0d",
                   o.ch, o.kind, o.cyc, e.ch, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_extra: %0d unexpected events, first ch%0d kind%0d edge %0d, required none",
               obs_q.size(), obs_q[0].ch, obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_press();
    ev_t e, o;
    int unsigned k, k2;
    raw_in[0] = 1'b1;
    k = cyc + 1;
    exp_q.push_back(mk_ev(k + LAT, 0, K_PRESS));
    for (int j = 0; j < int'(LAT) + 2; j++) begin
      step(1);
      if (cyc == k + LAT - 1) begin
        checks++;
        if (level !== '0) begin
          errors++;
          $display("FAIL press_early_level: got %b required 0", level);
        end
      end
      if (cyc == k + LAT) begin
        checks++;
        if (level !== 9'b000000001 || press !== 9'b000000001) begin
          errors++;
          $display("FAIL press_edge: got level %b press %b required 000000001 both", level, press);
        end
      end
      if (cyc == k + LAT + 1) begin
        checks++;
        if (press !== '0 || level !== 9'b000000001) begin
          errors++;
          $display("FAIL press_after: got press %b level %b required 0 and 000000001", press, level);
        end
      end
    end
    raw_in[0] = 1'b0;
    k2 = cyc + 1;
    exp_q.push_back(mk_ev(k2 + LAT, 0, K_REL));
    step(LAT + 2);
    #1;
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL press_final_level: got %b required 0", level);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL press_events: missing event, required ch%0d kind%0d edge %0d", e.ch, e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL press_events: got ch%0d kind%0d edge %0d required ch%0d kind%0d edge %0d",
                   o.ch, o.kind, o.cyc, e.ch, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL press_extra: %0d unexpected events, first ch%0d kind%0d edge %0d, required none",
               obs_q.size(), obs_q[0].ch, obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  // Bounces of 2,2 and D-1 samples high must all be discarded.
  task automatic test_bounce();
    for (int j = 0; j < 20; j++) begin
      raw_in[1] = (j < 2) || (j >= 4 && j < 6) || (j >= 8 && j < 8 + int'(D) - 1);
      step(1);
      checks++;
      if (level[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_level: cycle %0d got %b required 0", j, level[1]);
      end
    end
    #1;
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_extra: %0d unexpected events, first ch%0d kind%0d edge %0d, required none",
               obs_q.size(), obs_q[0].ch, obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  // Exactly D samples high is the shortest accepted press.
  task automatic test_min_pulse();
    ev_t e, o;
    int unsigned k;
    raw_in[8] = 1'b1;
    k = cyc + 1;
    exp_q.push_back(mk_ev(k + LAT, 8, K_PRESS));
    exp_q.push_back(mk_ev(k + D + LAT, 8, K_REL));
    step(D);
    raw_in[8] = 1'b0;
    step(LAT + 3);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL min_pulse_events: missing event, required ch%0d kind%0d edge %0d", e.ch, e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL min_pulse_events: got ch%0d kind%0d edge %0d required ch%0d kind%0d edge %0d",
                   o.ch, o.kind, o.cyc, e.ch, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL min_pulse_extra: %0d unexpected events, first ch%0d kind%0d edge %0d, required none",
               obs_q.size(), obs_q[0].ch, obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_release();
    ev_t e, o;
    int unsigned k, k2;
    raw_in[2] = 1'b1;
    k = cyc + 1;
    exp_q.push_back(mk_ev(k + LAT, 2, K_PRESS));
    step(LAT + 1);
    checks++;
    if (level[2] !== 1'b1) begin
      errors++;
      $display("FAIL release_held_level: got %b required 1", level[2]);
    end
    raw_in[2] = 1'b0;
    k2 = cyc + 1;
    exp_q.push_back(mk_ev(k2 + LAT, 2, K_REL));
    for (int j = 0; j < int'(LAT) + 2; j++) begin
      step(1);
      if (cyc == k2 + LAT - 1) begin
        checks++;
        if (level[2] !== 1'b1) begin
          errors++;
          $display("FAIL release_early_level: got %b required 1", level[2]);
        end
      end
      if (cyc == k2 + LAT) begin
        checks++;
        if (level[2] !== 1'b0 || release_pulse !== 9'b000000100) begin
          errors++;
          $display("FAIL release_edge: got level %b release %b required 0 and 000000100", level[2], release_pulse);
        end
      end
      if (cyc == k2 + LAT + 1) begin
        checks++;
        if (release_pulse !== '0) begin
          errors++;
          $display("FAIL release_after: got %b required 0", release_pulse);
        end
      end
    end
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL release_events: missing event, required ch%0d kind%0d edge %0d", e.ch, e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL release_events: got ch%0d kind%0d edge %0d required ch%0d kind%0d edge %0d",
                   o.ch, o.kind, o.cyc, e.ch, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL release_extra: %0d unexpected events, first ch%0d kind%0d edge %0d, required none",
               obs_q.size(), obs_q[0].ch, obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  // Reset mid-RISE_WAIT on ch3 while ch6 is already high; both pads stay high.
  task automatic test_reset_mid();
    ev_t e, o;
    int unsigned k, k2;
    raw_in[6] = 1'b1;
    k = cyc + 1;
    exp_q.push_back(mk_ev(k + LAT, 6, K_PRESS));
    step(LAT + 1);
    raw_in[3] = 1'b1;
    step(3);
    rst = 1'b1;
    #1;
    checks++;
    if ({level, press, release_pulse, repeat_pulse} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h required 0", {level, press, release_pulse, repeat_pulse});
    end
    step(3);
    rst = 1'b0;
    k = cyc + 1;
    exp_q.push_back(mk_ev(k + LAT, 3, K_PRESS));
    exp_q.push_back(mk_ev(k + LAT, 6, K_PRESS));
    step(LAT + 2);
    raw_in[3] = 1'b0;
    raw_in[6] = 1'b0;
    k2 = cyc + 1;
    exp_q.push_back(mk_ev(k2 + LAT, 3, K_REL));
    exp_q.push_back(mk_ev(k2 + LAT, 6, K_REL));
    step(LAT + 2);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL reset_mid_events: missing event, required ch%0d kind%0d edge %0d", e.ch, e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL reset_mid_events: got ch%0d kind%0d edge %0d required ch%0d kind%0d edge %0d",
                   o.ch, o.kind, o.cyc, e.ch, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_extra: %0d unexpected events, first ch%0d kind%0d edge %0d, required none",
               obs_q.size(), obs_q[0].ch, obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    ev_t e, o;
    int unsigned k, k2;
    raw_in[0] = 1'b1;
    raw_in[5] = 1'b1;
    k = cyc + 1;
    exp_q.push_back(mk_ev(k + LAT, 0, K_PRESS));
    exp_q.push_back(mk_ev(k + LAT, 5, K_PRESS));
    step(LAT + 1);
    checks++;
    if (press !== 9'b000100001) begin
      errors++;
      $display("FAIL simul_press: got %b required 000100001", press);
    end
    step(1);
    raw_in[0] = 1'b0;
    raw_in[5] = 1'b0;
    k2 = cyc + 1;
    exp_q.push_back(mk_ev(k2 + LAT, 0, K_REL));
    exp_q.push_back(mk_ev(k2 + LAT, 5, K_REL));
    step(LAT + 2);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL simul_events: missing event, required ch%0d kind%0d edge %0d", e.ch, e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL simul_events: got ch%0d kind%0d edge %0d required ch%0d kind%0d edge %0d",
                   o.ch, o.kind, o.cyc, e.ch, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL simul_extra: %0d unexpected events, first ch%0d kind%0d edge %0d, required none",
               obs_q.size(), obs_q[0].ch, obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  // Long hold on ch7; low is first sampled 25 edges after press.
  task automatic test_repeat();
    ev_t e, o;
    int unsigned k, p, k2;
    raw_in[7] = 1'b1;
    k = cyc + 1;
    p = k + LAT;
    exp_q.push_back(mk_ev(p, 7, K_PRESS));
`ifdef BTN_COND_REPEAT_EN
    for (int unsigned t = RD; t <= 26; t += RP) exp_q.push_back(mk_ev(p + t, 7, K_RPT));
`endif
    step(LAT + 1);
    step(24);
    raw_in[7] = 1'b0;
    k2 = cyc + 1;
    exp_q.push_back(mk_ev(k2 + LAT, 7, K_REL));
    step(LAT + 3);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL repeat_events: missing event, required ch%0d kind%0d edge %0d", e.ch, e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL repeat_events: got ch%0d kind%0d edge %0d required ch%0d kind%0d edge %0d",
                   o.ch, o.kind, o.cyc, e.ch, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL repeat_extra: %0d unexpected events, first ch%0d kind%0d edge %0d, required none",
               obs_q.size(), obs_q[0].ch, obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  initial begin
    rst    = 1'b1;
    raw_in = '0;
    test_reset();
    test_press();
    test_bounce();
    test_min_pulse();
    test_release();
    test_reset_mid();
    test_simultaneous();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
